// File: rtl/pe_add_pkg.sv
// Shared definitions for the pipelined PE add/subtract unit: op encodings,
// configuration checks and the 4-bit lookahead carry helper.
package pe_add_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages,
                                input int unsigned group);
    return (stages != 0) && (width % stages == 0) && ((width / stages) % 4 == 0) &&
           (width / stages != 0) && (group == 4);
  endfunction

  // Carry into each bit of a 4-bit group, written as flat sum-of-products.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c);
    logic [3:0] cb;
    cb[0] = c;
    cb[1] = g[0] | (p[0] & c);
    cb[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cb[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return cb;
  endfunction

endpackage

// File: rtl/pe_add_seg.sv
// Combinational SEG-bit two-level carry-lookahead adder segment built from
// 4-bit groups; exports segment propagate/generate alongside the carry out.
module pe_add_seg
  import pe_add_pkg::*;
#(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           p,
  output logic           g
);

  localparam int unsigned NG = SEG / 4;

  logic [SEG-1:0] bp, bg;
  logic [NG-1:0]  gp, gg;
  logic [NG:0]    gc;
  logic           acc, term;

  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    gp   = '0;
    gg   = '0;
    gc   = '0;
    acc  = 1'b0;
    term = 1'b0;
    sum  = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      gp[j] = &bp[4*j +: 4];
      gg[j] = bg[4*j+3] | (bp[4*j+3] & bg[4*j+2]) | (bp[4*j+3] & bp[4*j+2] & bg[4*j+1]) |
              (bp[4*j+3] & bp[4*j+2] & bp[4*j+1] & bg[4*j]);
    end
    // Group carries as independent products of group P/G, no chaining between groups.
    for (int unsigned j = 0; j <= NG; j++) begin
      acc = cin;
      for (int unsigned t = 0; t < j; t++) acc = acc & gp[t];
      for (int unsigned i = 0; i < j; i++) begin
        term = gg[i];
        for (int unsigned t = i + 1; t < j; t++) term = term & gp[t];
        acc = acc | term;
      end
      gc[j] = acc;
    end
    for (int unsigned j = 0; j < NG; j++)
      sum[4*j +: 4] = bp[4*j +: 4] ^ cla4(bg[4*j +: 4], bp[4*j +: 4], gc[j]);
    cout = gc[NG];
    p    = &gp;
    g    = 1'b0;
    for (int unsigned i = 0; i < NG; i++) begin
      term = gg[i];
      for (int unsigned t = i + 1; t < NG; t++) term = term & gp[t];
      g = g | term;
    end
  end

endmodule

// File: rtl/pe_add_pipe.sv
// Pipelined add/subtract unit: carry chain split into STAGES registered CLA
// segments with operand skew, result deskew and valid/ready backpressure.
module pe_add_pipe
  import pe_add_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4,
  parameter int unsigned GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG    = WIDTH / STAGES;
  localparam bit          CFG_OK = cfg_ok(WIDTH, STAGES, GROUP);

  if (!CFG_OK) begin : g_cfg_err
    $error("pe_add_pipe: WIDTH must split into STAGES segments of a multiple of 4 bits, GROUP=4");
  end

  logic              en;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] z_tap;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = v[STAGES-1];

  always_comb begin
    b_eff = b;
    c0    = 1'b0;
    case (op_e'(op))
      OP_SUB: begin
        b_eff = ~b;
        c0    = 1'b1;
      end
      OP_ADC:  c0 = cin;
      default: ;
    endcase
  end
  assign c_in[0] = c0;

  // Each register at pipeline depth m loads only when a valid beat arrives,
  // so bubbles leave the final outputs holding the last result.
  always_comb begin
    ld    = '0;
    ld[0] = en & in_valid;
    for (int unsigned m = 1; m < STAGES; m++) ld[m] = en & v[m-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (en) begin
      v[0] <= in_valid;
      for (int unsigned m = 1; m < STAGES; m++) v[m] <= v[m-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG-1:0] a_op, b_op, s_comb;
    logic           c_comb, seg_p, seg_g;
    logic [SEG-1:0] r_sum [k:STAGES-1];

    if (k == 0) begin : g_direct
      assign a_op = a[0 +: SEG];
      assign b_op = b_eff[0 +: SEG];
    end else begin : g_skew
      logic [SEG-1:0] a_sk [k];
      logic [SEG-1:0] b_sk [k];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < k; j++) begin
            a_sk[j] <= '0;
            b_sk[j] <= '0;
          end
        end else begin
          if (ld[0]) begin
            a_sk[0] <= a[k*SEG +: SEG];
            b_sk[0] <= b_eff[k*SEG +: SEG];
          end
          for (int unsigned j = 1; j < k; j++) begin
            if (ld[j]) begin
              a_sk[j] <= a_sk[j-1];
              b_sk[j] <= b_sk[j-1];
            end
          end
        end
      end
      assign a_op = a_sk[k-1];
      assign b_op = b_sk[k-1];
    end

    pe_add_seg #(.SEG(SEG)) u_seg (
      .a    (a_op),
      .b    (b_op),
      .cin  (c_in[k]),
      .sum  (s_comb),
      .cout (c_comb),
      .p    (seg_p),
      .g    (seg_g)
    );

    always_comb begin
      assert (c_comb == (seg_g | (seg_p & c_in[k])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned m = k; m < STAGES; m++) r_sum[m] <= '0;
      end else begin
        if (ld[k]) r_sum[k] <= s_comb;
        for (int unsigned m = k + 1; m < STAGES; m++)
          if (ld[m]) r_sum[m] <= r_sum[m-1];
      end
    end
    assign sum[k*SEG +: SEG] = r_sum[STAGES-1];

    if (k < STAGES - 1) begin : g_carry
      logic r_c;
      logic r_z [k:STAGES-2];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_c <= 1'b0;
          for (int unsigned m = k; m < STAGES - 1; m++) r_z[m] <= 1'b0;
        end else begin
          if (ld[k]) begin
            r_c    <= c_comb;
            r_z[k] <= ~|s_comb;
          end
          for (int unsigned m = k + 1; m < STAGES - 1; m++)
            if (ld[m]) r_z[m] <= r_z[m-1];
        end
      end
      assign c_in[k+1] = r_c;
      // Tapped one stage early so it meets the top segment at the final register.
      assign z_tap[k]  = r_z[STAGES-2];
    end else begin : g_flags
      assign z_tap[k] = ~|s_comb;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (ld[k]) begin
          cout <= c_comb;
          ovf  <= (a_op[SEG-1] == b_op[SEG-1]) & (s_comb[SEG-1] != a_op[SEG-1]);
          zero <= &z_tap;
        end
      end
    end
  end

endmodule

// File: doc/pe_add_pipe.md
Name: pe_add_pipe

Overview:
- Parametrised, pipelined carry-lookahead add/subtract unit. Next-generation replacement for the fixed 64-bit buffered adder in the PE datapath.
- Operand width and pipeline depth are configurable. The carry chain is split into STAGES registered segments.
- Adds an operation mode (add, subtract, add-with-carry), signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits between the PE operand registers and the PE result writeback.

Parameters:
- WIDTH, 64: operand and result width in bits. Must be a multiple of STAGES.
- STAGES, 4: number of pipeline segments. Each segment is SEG = WIDTH/STAGES bits, and SEG must be a multiple of 4. Latency is STAGES cycles.
- GROUP, 4: lookahead group size inside a segment. Fixed at 4 for now; the parameter is for future use.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- op  in  2  00 add a+b; 01 sub a-b; 10 add a+b+cin; 11 reserved, treated as add.
- cin  in  1  carry in. Used only when op=10.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For sub this is 1 when no borrow occurs (a>=b unsigned).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum equals all zeros.

Behaviour:
- Reset (asynchronous on rst_n low):
  - All stage valid bits clear, so out_valid=0.
  - sum, cout, ovf and zero are all 0.
  - in_ready = 1 after reset is released.
- Global advance enable: en = out_ready | ~out_valid. in_ready = en (combinational).
- A beat is accepted when in_valid & in_ready.
- Stage valids shift on en. Bubbles are not squeezed.
- On en=0, every pipeline register holds its value.
- Operand preparation in stage 0:
  - b_eff = op==01 ? ~b : b.
  - c0 = op==01 ? 1 : (op==10 ? cin : 0).
- Stage k (0..STAGES-1):
  - Computes segment k, bits [k*SEG +: SEG], from its skewed operand slice and the registered carry out of stage k-1. Stage 0 uses c0.
  - The segment uses 4-bit CLA groups, with group P/G combined lookahead across groups, so there is no ripple between bits.
  - Registers the segment sum, the segment carry and the valid bit.
- Operand skew: segment k operands enter through k delay registers. Result deskew: the sum of segment k passes through STAGES-1-k delay registers. All slices of one beat emerge together.
- Latency: a beat accepted at edge n presents at the outputs after edge n+STAGES-1, provided no stall occurs. Throughput is 1 beat per cycle.
- Flags are computed in the last stage:
  - cout = carry out of segment STAGES-1.
  - ovf = (a[W-1]==b_eff[W-1]) & (sum[W-1]!=a[W-1]). The a/b_eff MSBs travel in the top-segment skew.
  - zero = ~|sum. It is registered alongside the final segment; the partial zero of each lower segment is carried in its deskew path.
- Outputs hold stable while out_valid & ~out_ready.
- When out_valid=0, sum, cout, ovf and zero hold their last values. Consumers ignore them.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- STAGES=1 degenerates to a single registered CLA with 1-cycle latency. Skew/deskew registers are absent.

Decomposition:
- Shared package pe_add_pkg:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10.
  - function clog2.
  - localparam check (WIDTH%STAGES==0, SEG%4==0); an elaboration error is raised on violation.
- Sub-module pe_add_seg (combinational, parameter SEG):
  - Inputs: a, b, cin.
  - Outputs: sum, cout, group P, group G.
  - Implemented as a two-level 4-bit CLA. Instantiated once per stage.
- All registers, skew/deskew and handshake logic live in pe_add_pipe.

Test Plan:
- Defaults, out_ready=1. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → after 4 cycles sum=0, cout=1, zero=1, ovf=0. This exercises carry crossing all segments.
- Sub 0x8000_0000_0000_0000 - 0x1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1. Then sub 0x5 - 0x7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Op=10 with cin=1: 0x7FFF_FFFF_FFFF_FFFF + 0 → sum=0x8000_0000_0000_0000, ovf=1. A second beat with op=00 and cin=1 ignores cin: 3+4 gives sum=7.
- Back-to-back stream of 8 beats (a=i, b=i*3), then out_ready=0 for 3 cycles mid-stream:
  - Outputs hold.
  - in_ready=0 while out_valid=1.
  - All 8 results arrive in order, equal to 4*i, with none lost or duplicated.
- Assert rst_n low for 1 cycle with 3 beats in flight → out_valid=0 and all outputs 0 immediately. The next accepted beat returns correctly with latency 4.
- Re-elaborate with WIDTH=32, STAGES=1 and WIDTH=128, STAGES=8. Run 1000 random beats per config against a reference model for all ops. Latency must equal STAGES.
